// File: rtl/uart_rx_segment_display_if.sv
// Serial-in / display-out bundle for uart_rx_segment_display.
// The slave modport is the receiver side; the master modport drives the line.
interface uart_rx_segment_display_if;
  logic       rx_in;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       digit_valid;
  logic       leda;
  logic       ledb;
  logic       ledc;
  logic       ledd;
  logic       lede;
  logic       ledf;
  logic       ledg;

  modport master (
    output rx_in,
    input  data_out, rx_valid, frame_err, digit_valid,
    input  leda, ledb, ledc, ledd, lede, ledf, ledg
  );

  modport slave (
    input  rx_in,
    output data_out, rx_valid, frame_err, digit_valid,
    output leda, ledb, ledc, ledd, lede, ledf, ledg
  );
endinterface

// File: rtl/uart_rx_segment_display.sv
// 8N1 UART receiver driving a 7-segment digit from received ASCII digits.
// Define HEX_DIGITS_EN to also display A-F / a-f.
module uart_rx_segment_display #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned CNT_W        = 13
) (
  input  logic                        clk,
  input  logic                        n_reset,
  uart_rx_segment_display_if.slave    bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  localparam logic [CNT_W-1:0] LP_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic             r_digit_valid;
  logic [6:0]       r_seg;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic [7:0]       w_dec;

  // Returns {decodable, seg a..g}.
  function automatic logic [7:0] f_decode(input logic [7:0] b);
    case (b)
      8'h30:        f_decode = {1'b1, 7'b1111110};
      8'h31:        f_decode = {1'b1, 7'b0110000};
      8'h32:        f_decode = {1'b1, 7'b1101101};
      8'h33:        f_decode = {1'b1, 7'b1111001};
      8'h34:        f_decode = {1'b1, 7'b0110011};
      8'h35:        f_decode = {1'b1, 7'b1011011};
      8'h36:        f_decode = {1'b1, 7'b1011111};
      8'h37:        f_decode = {1'b1, 7'b1110000};
      8'h38:        f_decode = {1'b1, 7'b1111111};
      8'h39:        f_decode = {1'b1, 7'b1111011};
`ifdef HEX_DIGITS_EN
      8'h41, 8'h61: f_decode = {1'b1, 7'b1110111};
      8'h42, 8'h62: f_decode = {1'b1, 7'b0011111};
      8'h43, 8'h63: f_decode = {1'b1, 7'b1001110};
      8'h44, 8'h64: f_decode = {1'b1, 7'b0111101};
      8'h45, 8'h65: f_decode = {1'b1, 7'b1001111};
      8'h46, 8'h66: f_decode = {1'b1, 7'b1000111};
`endif
      default:      f_decode = 8'h00;
    endcase
  endfunction

  assign w_dec = f_decode(r_shift);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx_in;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shift       <= '0;
      r_data        <= 8'h30;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_digit_valid <= 1'b0;
      r_seg         <= 7'b1111110;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (r_cnt == LP_HALF) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_state <= r_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == LP_LAST) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= r_rx_s;
            if (r_idx == 3'd7) r_state <= STOP;
            else               r_idx   <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == LP_LAST) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_data     <= r_shift;
              r_rx_valid <= 1'b1;
              r_state    <= IDLE;
              // Display follows data_out in the same cycle rx_valid rises.
              if (w_dec[7]) begin
                r_seg         <= w_dec[6:0];
                r_digit_valid <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (r_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.data_out    = r_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.frame_err   = r_frame_err;
  assign bus.digit_valid = r_digit_valid;
  assign bus.leda        = r_seg[6];
  assign bus.ledb        = r_seg[5];
  assign bus.ledc        = r_seg[4];
  assign bus.ledd        = r_seg[3];
  assign bus.lede        = r_seg[2];
  assign bus.ledf        = r_seg[1];
  assign bus.ledg        = r_seg[0];

endmodule
